// File: rtl/iob_plic_pkg.sv
// Shared definitions for the PLIC interrupt gateways: per-source FSM encoding
// and the width of the queued-edge counter.
package iob_plic_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPending = 2'd1,
        StClaimed = 2'd2
    } gw_state_e;

    // The counter must be able to hold 0..max_count inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        if (max_count < 1) begin
            return 1;
        end
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/iob_plic_gateway_cell.sv
// Single-source interrupt gateway: IDLE/PENDING/CLAIMED FSM, rising-edge detector
// and a saturating count of edges not yet claimed.
module iob_plic_gateway_cell
    import iob_plic_pkg::*;
#(
    parameter int unsigned MAX_PENDING_COUNT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic el,
    input  logic claim,
    input  logic complete,
    output logic ip
);

    localparam int unsigned CW = cnt_width(MAX_PENDING_COUNT);
    localparam logic [CW-1:0] CntMax = CW'(MAX_PENDING_COUNT);

    gw_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            src_prev_q;
    logic            rise;
    logic            claim_acc;

    // src_prev_q tracks src in both modes so a switch to edge mode never sees a
    // stale low and fakes a rise.
    assign rise      = el & src & ~src_prev_q;
    assign claim_acc = (state_q == StPending) & claim;

    always_comb begin
        cnt_d = cnt_q;
        if (!el) begin
            cnt_d = '0;
        end else if (rise && !claim_acc) begin
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (claim_acc && !rise) begin
            // Guard against PENDING entered in level mode, where nothing was counted.
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (el ? ((cnt_q != '0) || rise) : src) begin
                    state_d = StPending;
                end
            end
            StPending: begin
                if (claim) begin
                    state_d = StClaimed;
                end
            end
            StClaimed: begin
                if (complete) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            src_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            src_prev_q <= src;
        end
    end

    assign ip = (state_q == StPending);

endmodule

// File: rtl/iob_plic_gateway.sv
// PLIC gateway array: one independent gateway cell per interrupt source, with ip
// driven straight from each cell's registered state.
module iob_plic_gateway
    import iob_plic_pkg::*;
#(
    parameter int unsigned SOURCES           = 8,
    parameter int unsigned MAX_PENDING_COUNT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SOURCES-1:0] src,
    input  logic [SOURCES-1:0] el,
    input  logic [SOURCES-1:0] claim,
    input  logic [SOURCES-1:0] complete,
    output logic [SOURCES-1:0] ip
);

    for (genvar g = 0; g < SOURCES; g++) begin : g_cell
        iob_plic_gateway_cell #(
            .MAX_PENDING_COUNT(MAX_PENDING_COUNT)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .src      (src[g]),
            .el       (el[g]),
            .claim    (claim[g]),
            .complete (complete[g]),
            .ip       (ip[g])
        );
    end

endmodule

// File: tb/tb_iob_plic_gateway.sv
// Scoreboard bench for iob_plic_gateway: directed vectors push the hand-computed ip
// expected after each edge; a monitor pops and compares after every rising edge.
module tb_iob_plic_gateway;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] src = '0;
    logic [7:0] el = '0;
    logic [7:0] claim = '0;
    logic [7:0] complete = '0;
    logic [7:0] ip;
    logic [7:0] el_v = '0;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    iob_plic_gateway #(
        .SOURCES           (8),
        .MAX_PENDING_COUNT (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .src      (src),
        .el       (el),
        .claim    (claim),
        .complete (complete),
        .ip       (ip)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the ip expected after the next edge.
    task automatic cyc(input logic [7:0] s, input logic [7:0] c, input logic [7:0] p,
                       input logic r, input logic [7:0] e, input string nm);
        @(negedge clk);
        src      = s;
        claim    = c;
        complete = p;
        rst      = r;
        el       = el_v;
        exp_q.push_back('{exp: e, name: nm});
    endtask

    // Claim, complete, then one idle cycle whose ip is the re-assert check.
    task automatic round(input logic [7:0] s, input logic [7:0] m,
                         input logic [7:0] after, input string nm);
        cyc(s, m, 8'h00, 1'b0, 8'h00, {nm, "_claim"});
        cyc(s, 8'h00, m, 1'b0, 8'h00, {nm, "_cmpl"});
        cyc(s, 8'h00, 8'h00, 1'b0, after, {nm, "_after"});
    endtask

    initial begin : monitor
        exp_t t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                t = exp_q.pop_front();
                tests++;
                if (ip !== t.exp) begin
                    fails++;
                    $display("FAIL %s: ip=%b expected=%b", t.name, ip, t.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // Reset
        el_v = 8'h00;
        cyc(8'h00, 8'h00, 8'h00, 1'b1, 8'h00, "reset0");
        cyc(8'hFF, 8'hFF, 8'hFF, 1'b1, 8'h00, "reset_override");
        cyc(8'h00, 8'h00, 8'h00, 1'b0, 8'h00, "reset_idle");

        // Level mode on source 0
        cyc(8'h01, 8'h00, 8'h00, 1'b0, 8'h01, "lvl_pend");
        cyc(8'h01, 8'h00, 8'h00, 1'b0, 8'h01, "lvl_hold");
        cyc(8'h00, 8'h00, 8'h00, 1'b0, 8'h01, "lvl_sticky");
        cyc(8'h00, 8'h01, 8'h00, 1'b0, 8'h00, "lvl_claim");
        cyc(8'h01, 8'h00, 8'h00, 1'b0, 8'h00, "lvl_claimed");
        cyc(8'h01, 8'h00, 8'h01, 1'b0, 8'h00, "lvl_cmpl");
        cyc(8'h01, 8'h00, 8'h00, 1'b0, 8'h01, "lvl_reenter");
        round(8'h00, 8'h01, 8'h00, "lvl_done");

        // Spurious handshakes in level mode
        cyc(8'h00, 8'h01, 8'h00, 1'b0, 8'h00, "spur_claim_idle");
        cyc(8'h00, 8'h00, 8'h01, 1'b0, 8'h00, "spur_cmpl_idle");
        cyc(8'h01, 8'h00, 8'h00, 1'b0, 8'h01, "spur_pend");
        cyc(8'h00, 8'h00, 8'h01, 1'b0, 8'h01, "spur_cmpl_pend");
        round(8'h00, 8'h01, 8'h00, "spur_lvl");

        // Edge queueing on source 1: three pulses, three rounds
        el_v = 8'h06;
        cyc(8'h00, 8'h00, 8'h00, 1'b0, 8'h00, "edge_switch");
        for (int k = 0; k < 3; k++) begin
            cyc(8'h02, 8'h00, 8'h00, 1'b0, 8'h02, "edge_pulse_hi");
            cyc(8'h00, 8'h00, 8'h00, 1'b0, 8'h02, "edge_pulse_lo");
        end
        round(8'h00, 8'h02, 8'h02, "edge_r1");
        round(8'h00, 8'h02, 8'h02, "edge_r2");
        round(8'h00, 8'h02, 8'h00, "edge_r3");
        cyc(8'h00, 8'h00, 8'h00, 1'b0, 8'h00, "edge_empty");

        // Spurious handshakes in edge mode leave the count alone
        cyc(8'h00, 8'h02, 8'h00, 1'b0, 8'h00, "espur_claim_idle");
        cyc(8'h02, 8'h00, 8'h00, 1'b0, 8'h02, "espur_pulse");
        cyc(8'h00, 8'h00, 8'h02, 1'b0, 8'h02, "espur_cmpl_pend");
        round(8'h00, 8'h02, 8'h00, "espur");

        // Edge arriving while CLAIMED is queued
        cyc(8'h02, 8'h00, 8'h00, 1'b0, 8'h02, "ecl_pulse");
        cyc(8'h00, 8'h02, 8'h00, 1'b0, 8'h00, "ecl_claim");
        cyc(8'h02, 8'h00, 8'h00, 1'b0, 8'h00, "ecl_rise_claimed");
        cyc(8'h00, 8'h00, 8'h02, 1'b0, 8'h00, "ecl_cmpl");
        cyc(8'h00, 8'h00, 8'h00, 1'b0, 8'h02, "ecl_reenter");
        round(8'h00, 8'h02, 8'h00, "ecl_drain");

        // Simultaneous rise and claim on source 2 with count=1
        cyc(8'h04, 8'h00, 8'h00, 1'b0, 8'h04, "rc_pulse");
        cyc(8'h00, 8'h00, 8'h00, 1'b0, 8'h04, "rc_lo");
        cyc(8'h04, 8'h04, 8'h00, 1'b0, 8'h00, "rc_rise_claim");
        cyc(8'h00, 8'h00, 8'h04, 1'b0, 8'h00, "rc_cmpl");
        cyc(8'h00, 8'h00, 8'h00, 1'b0, 8'h04, "rc_reassert");
        round(8'h00, 8'h04, 8'h00, "rc_drain");

        // Saturation: 10 pulses, only 8 rounds
        for (int k = 0; k < 10; k++) begin
            cyc(8'h02, 8'h00, 8'h00, 1'b0, 8'h02, "sat_pulse_hi");
            cyc(8'h00, 8'h00, 8'h00, 1'b0, 8'h02, "sat_pulse_lo");
        end
        for (int r = 0; r < 8; r++) begin
            round(8'h00, 8'h02, (r < 7) ? 8'h02 : 8'h00, "sat_round");
        end
        cyc(8'h00, 8'h00, 8'h00, 1'b0, 8'h00, "sat_9th_absent");

        // Two sources, different modes, handled together
        cyc(8'h03, 8'h00, 8'h00, 1'b0, 8'h03, "multi_pend");
        cyc(8'h01, 8'h00, 8'h00, 1'b0, 8'h03, "multi_hold");
        cyc(8'h00, 8'h03, 8'h00, 1'b0, 8'h00, "multi_claim");
        cyc(8'h00, 8'h00, 8'h01, 1'b0, 8'h00, "multi_cmpl0");
        cyc(8'h00, 8'h00, 8'h02, 1'b0, 8'h00, "multi_cmpl1");
        cyc(8'h00, 8'h00, 8'h00, 1'b0, 8'h00, "multi_idle");

        // Mode switch: state kept, queued count dropped
        cyc(8'h02, 8'h00, 8'h00, 1'b0, 8'h02, "mode_p1");
        cyc(8'h00, 8'h00, 8'h00, 1'b0, 8'h02, "mode_p1_lo");
        cyc(8'h02, 8'h00, 8'h00, 1'b0, 8'h02, "mode_p2");
        cyc(8'h00, 8'h00, 8'h00, 1'b0, 8'h02, "mode_p2_lo");
        el_v = 8'h04;
        cyc(8'h00, 8'h00, 8'h00, 1'b0, 8'h02, "mode_keep_state");
        round(8'h00, 8'h02, 8'h00, "mode_cnt_cleared");

        // Reset mid-operation: source 0 CLAIMED with count=4, src held high
        el_v = 8'h07;
        cyc(8'h00, 8'h00, 8'h00, 1'b0, 8'h00, "rst_setup");
        for (int k = 0; k < 5; k++) begin
            cyc(8'h01, 8'h00, 8'h00, 1'b0, 8'h01, "rst_pulse_hi");
            cyc(8'h00, 8'h00, 8'h00, 1'b0, 8'h01, "rst_pulse_lo");
        end
        cyc(8'h00, 8'h01, 8'h00, 1'b0, 8'h00, "rst_claim");
        cyc(8'h01, 8'h01, 8'h01, 1'b1, 8'h00, "rst_mid");
        cyc(8'h01, 8'h00, 8'h00, 1'b0, 8'h01, "rst_rise");
        round(8'h01, 8'h01, 8'h00, "rst_cnt_cleared");
        cyc(8'h01, 8'h00, 8'h00, 1'b0, 8'h00, "rst_no_rise");

        @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iob_plic_gateway.md
IOB_PLIC_GATEWAY -- requirements
Module: iob_plic_gateway

Interface
REQ-001 Parameter SOURCES, default 8: number of interrupt sources handled; each has an independent gateway.
REQ-002 Parameter MAX_PENDING_COUNT, default 8: per-source saturation limit of queued edge events (>=1).
REQ-003 Port clk  input  1: the block's only clock; all state changes on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port src  input  SOURCES: raw interrupt requests, already synchronous to clk.
REQ-006 Port el  input  SOURCES: per-source mode; 1 = edge-triggered, 0 = level-triggered.
REQ-007 Port claim  input  SOURCES: per-source claim pulse from the PLIC core, one cycle wide.
REQ-008 Port complete  input  SOURCES: per-source completion pulse from the PLIC core, one cycle wide.
REQ-009 Port ip  output  SOURCES: interrupt-pending towards the PLIC core; ip[i] = 1 iff source i is in PENDING.

Function
REQ-010 Each source SHALL run a 3-state FSM: IDLE, PENDING, CLAIMED; ip is decoded from the registered state (no combinational path from src).
REQ-011 Level mode: IDLE with src[i]=1 at an edge -> PENDING after that edge (ip high 1 cycle after src is sampled high).
REQ-012 PENDING with claim[i]=1 -> CLAIMED; ip[i] drops the cycle after the claim.
REQ-013 CLAIMED with complete[i]=1 -> IDLE; a still-high level src re-enters PENDING on the following edge.
REQ-014 Level mode: src falling while PENDING SHALL NOT withdraw ip (sticky until claimed).
REQ-015 Edge mode: rise = src[i]=1 and previous-cycle src[i]=0; a per-source counter of width clog2(MAX_PENDING_COUNT+1) holds unclaimed edges.
REQ-016 Edge mode counter update: +1 on rise, -1 on claim accepted in PENDING; simultaneous rise and accepted claim leave it unchanged.
REQ-017 Counter saturates at MAX_PENDING_COUNT; a rise at saturation without a simultaneous claim is dropped.
REQ-018 Edge mode: IDLE moves to PENDING on the edge where count>0 or rise=1 (1-cycle latency from sampled rise).
REQ-019 Edge mode: CLAIMED + complete -> IDLE; if count>0 afterwards, PENDING is re-entered on the next edge.
REQ-020 claim in IDLE or CLAIMED, and complete in IDLE or PENDING, SHALL be ignored with no state or counter change.
REQ-021 Edges arriving while CLAIMED SHALL be counted (subject to saturation), never lost below the limit.
REQ-022 Change of el[i] takes effect on the next edge; on transition to level mode the counter clears to 0; FSM state is kept.
REQ-023 Sources SHALL be fully independent; multi-bit claim/complete vectors are processed per bit.

Reset
REQ-024 rst=1 at a clock edge: all FSMs to IDLE, counters to 0, previous-src registers to 0; ip=0 the cycle after.
REQ-025 rst mid-operation (PENDING or CLAIMED) discards all queued events; a src held high after reset is seen as a new rise in edge mode.
REQ-026 rst overrides src, claim and complete in the same cycle.

Structure
REQ-027 Shared package iob_plic_pkg: FSM state encoding (IDLE, PENDING, CLAIMED), counter-width constant/function.
REQ-028 One sub-module iob_plic_gateway_cell (single source: FSM, edge detector, counter), instantiated SOURCES times by generate.
REQ-029 The ip vector connects directly to the PLIC core's source inputs; no extra pipeline stage.

Verification
REQ-030 Level: el=0, src[0]=1 at cycle 5 -> ip[0]=1 at cycle 6; claim cycle 8 -> ip[0]=0 cycle 9; complete cycle 12 with src high -> ip[0]=1 cycle 14.
REQ-031 Edge queueing: el[1]=1, 3 one-cycle pulses on src[1] -> ip[1] high; 3 claim/complete rounds each reassert ip; after the 3rd complete ip[1] stays 0.
REQ-032 Saturation: MAX_PENDING_COUNT=8, 10 pulses with no claim -> exactly 8 claim/complete rounds produce ip; 9th absent.
REQ-033 Simultaneous rise and claim on source 2 with count=1 -> count stays 1, state CLAIMED, ip re-asserts after complete.
REQ-034 Spurious handshakes: claim in IDLE, complete in PENDING -> no change to ip or count.
REQ-035 Reset mid-operation: source 0 CLAIMED with count=4, rst for 1 cycle -> ip=0, count=0; src held high -> ip re-asserts 2 cycles after rst release (edge mode, seen as rise).
